// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: stores stream samples in a circular data RAM,
// walks the taps to drive the MAC, and streams each result out.
module fir_tap_sequencer #(
  parameter int NTAP   = 11,
  parameter int ADDR_W = 12,
  parameter int DW     = 32
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              ap_start,
  input  logic [31:0]       data_length,
  output logic              ap_idle,
  output logic              ap_done,
  output logic              tlast_err,
  input  logic              ss_tvalid,
  input  logic [DW-1:0]     ss_tdata,
  input  logic              ss_tlast,
  output logic              ss_tready,
  output logic              sm_tvalid,
  output logic [DW-1:0]     sm_tdata,
  output logic              sm_tlast,
  input  logic              sm_tready,
  output logic              tap_EN,
  output logic [ADDR_W-1:0] tap_A,
  output logic              data_EN,
  output logic [3:0]        data_WE,
  output logic [ADDR_W-1:0] data_A,
  output logic [DW-1:0]     data_Di,
  output logic              mac_EN,
  output logic              mac_clr,
  input  logic [DW-1:0]     mac_result
);

  localparam int IW = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam logic [IW:0] NT = (IW+1)'(NTAP);
  localparam logic [IW-1:0] KMAX = IW'(NTAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_MAC,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [IW-1:0] k;
  logic [IW-1:0] wp;
  logic [31:0]   cnt;
  logic [31:0]   len;
  logic          err;

  logic          k_last;
  logic          last_smp;
  logic [IW-1:0] wp_inc;
  logic [IW:0]   rd_idx;

  function automatic logic [ADDR_W-1:0] baddr(
    input logic [IW-1:0] i
  );
    return ADDR_W'({i, 2'b00});
  endfunction

  assign k_last   = (k == KMAX);
  assign last_smp = (cnt == len - 32'd1);
  assign wp_inc   = (wp == KMAX) ? '0 : wp + 1'b1;

  // circular read index (wp - k) mod NTAP without a divider
  always_comb begin
    rd_idx = {1'b0, wp} - {1'b0, k};
    if (wp < k)
      rd_idx = {1'b0, wp} + NT - {1'b0, k};
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state <= S_IDLE;
      k     <= '0;
      wp    <= '0;
      cnt   <= '0;
      len   <= '0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: begin
          if (ap_start) begin
            len <= data_length;
            err <= 1'b0;
            k   <= '0;
          end
        end
        S_CLEAR: begin
          k   <= k_last ? '0 : k + 1'b1;
          wp  <= '0;
          cnt <= '0;
        end
        S_WAIT: begin
          if (ss_tvalid) begin
            k <= '0;
            if (ss_tlast != last_smp)
              err <= 1'b1;
          end
        end
        S_MAC: begin
          k <= k_last ? '0 : k + 1'b1;
        end
        S_OUT: begin
          if (sm_tready) begin
            wp  <= wp_inc;
            cnt <= cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (ap_start) nxt = S_CLEAR;
      S_CLEAR:
        if (k_last)
          nxt = (len == 32'd0) ? S_DONE : S_WAIT;
      S_WAIT:
        if (ss_tvalid) nxt = S_MAC;
      S_MAC:
        if (k_last) nxt = S_DRAIN;
      S_DRAIN:
        nxt = S_OUT;
      S_OUT:
        if (sm_tready)
          nxt = (cnt + 32'd1 == len) ? S_DONE : S_WAIT;
      S_DONE:
        nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
  end

  assign tlast_err = err;

  always_comb begin
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tdata  = '0;
    sm_tlast  = 1'b0;
    tap_EN    = 1'b0;
    tap_A     = '0;
    data_EN   = 1'b0;
    data_WE   = 4'h0;
    data_A    = '0;
    data_Di   = '0;
    mac_EN    = 1'b0;
    mac_clr   = 1'b0;
    unique case (state)
      S_IDLE: ap_idle = 1'b1;
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = baddr(k);
      end
      S_WAIT: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          data_A  = baddr(wp);
          data_Di = ss_tdata;
          mac_clr = 1'b1;
        end
      end
      S_MAC: begin
        tap_EN  = 1'b1;
        tap_A   = baddr(k);
        data_EN = 1'b1;
        data_A  = baddr(rd_idx[IW-1:0]);
        // RAM data lags the address by one cycle
        mac_EN  = (k != '0);
      end
      S_DRAIN: mac_EN = 1'b1;
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tdata  = mac_result;
        sm_tlast  = last_smp;
      end
      S_DONE: ap_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: behavioural tap/data RAMs and MAC,
// direct-convolution reference pushed to a scoreboard queue.
module tb_fir_tap_sequencer;

  localparam int NTAP   = 11;
  localparam int ADDR_W = 12;
  localparam int DW     = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ap_start = 1'b0;
  logic [31:0]       data_length = '0;
  logic              ap_idle, ap_done, tlast_err;
  logic              ss_tvalid = 1'b0;
  logic [DW-1:0]     ss_tdata = '0;
  logic              ss_tlast = 1'b0;
  logic              ss_tready;
  logic              sm_tvalid;
  logic [DW-1:0]     sm_tdata;
  logic              sm_tlast;
  logic              sm_tready = 1'b1;
  logic              tap_EN;
  logic [ADDR_W-1:0] tap_A;
  logic              data_EN;
  logic [3:0]        data_WE;
  logic [ADDR_W-1:0] data_A;
  logic [DW-1:0]     data_Di;
  logic              mac_EN, mac_clr;
  logic [DW-1:0]     mac_result;

  fir_tap_sequencer #(
    .NTAP(NTAP), .ADDR_W(ADDR_W), .DW(DW)
  ) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .ap_start(ap_start), .data_length(data_length),
    .ap_idle(ap_idle), .ap_done(ap_done),
    .tlast_err(tlast_err),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata),
    .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata),
    .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .tap_EN(tap_EN), .tap_A(tap_A),
    .data_EN(data_EN), .data_WE(data_WE),
    .data_A(data_A), .data_Di(data_Di),
    .mac_EN(mac_EN), .mac_clr(mac_clr),
    .mac_result(mac_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] tap_mem [16];
  logic [31:0] data_mem [16];
  logic [31:0] tap_q, data_q, acc;

  always @(posedge clk) begin
    if (tap_EN) tap_q <= tap_mem[tap_A[5:2]];
    if (data_EN) begin
      if (data_WE == 4'hF) data_mem[data_A[5:2]] <= data_Di;
      data_q <= data_mem[data_A[5:2]];
    end
    if (mac_clr) acc <= '0;
    else if (mac_EN) acc <= acc + tap_q * data_q;
  end
  assign mac_result = acc;

  logic any_out;
  assign any_out = |{ap_done, tlast_err, ss_tready,
    sm_tvalid, sm_tdata, sm_tlast, tap_EN, tap_A,
    data_EN, data_WE, data_A, data_Di, mac_EN, mac_clr};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] y;
    logic        last;
  } exp_t;
  exp_t exp_q [$];
  exp_t e;

  logic [31:0] xs [64];

  int out_n = 0, done_n = 0, acc_cyc = 0, done_cyc = 0;
  int clr_cyc = 0, en_first = 0, en_last = 0, en_n = 0;
  int vld_first = -1, strm_n = 0, hs_cyc = 0, st_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sm_tvalid && sm_tready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("y", sm_tdata, e.y);
          chk("sm_tlast", sm_tlast, e.last);
        end
        out_n++;
        acc_cyc = cyc;
      end
      if (ap_done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (mac_clr) clr_cyc = cyc;
      if (mac_EN) begin
        if (en_n == 0) en_first = cyc;
        en_last = cyc;
        en_n++;
      end
      if (sm_tvalid && vld_first < 0) vld_first = cyc;
      if (ss_tready || sm_tvalid) strm_n++;
    end
  end

  function automatic logic [31:0] ref_y(int n);
    logic [31:0] s = '0;
    for (int k = 0; k < NTAP; k++)
      if (n - k >= 0) s += tap_mem[k] * xs[n-k];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(int len);
    data_length = len;
    ap_start = 1'b1;
    @(negedge clk);
    st_cyc = cyc;
    tick();
    ap_start = 1'b0;
    chk("idle_busy", ap_idle, 0);
    chk("tlast_clr", tlast_err, 0);
  endtask

  task automatic backpressure(int o0);
    int b = 0;
    int bad = 0;
    logic [31:0] hold;
    @(negedge clk);
    while (!sm_tvalid && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (!sm_tvalid) chk("tmo_bp", 0, 1);
    hold = sm_tdata;
    repeat (20) begin
      @(negedge clk);
      if (sm_tdata !== hold || !sm_tvalid ||
          ss_tready || mac_EN) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_held", out_n, o0);
    tick();
    sm_tready = 1'b1;
  endtask

  task automatic run(int len, int bp_n, bit bad_last,
                     bit mid_start);
    int d0 = done_n;
    int b;
    start(len);
    for (int n = 0; n < len; n++) begin
      exp_q.push_back('{ref_y(n), n == len - 1});
      if (n == bp_n) sm_tready = 1'b0;
      ss_tvalid = 1'b1;
      ss_tdata  = xs[n];
      ss_tlast  = bad_last ? 1'b0 : (n == len - 1);
      b = 0;
      @(negedge clk);
      while (!ss_tready && b < 200) begin
        @(negedge clk);
        b++;
      end
      if (!ss_tready) chk("tmo_ss", 0, 1);
      hs_cyc = cyc;
      tick();
      ss_tvalid = 1'b0;
      if (mid_start && n == 0) begin
        data_length = 5;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        data_length = len;
      end
      if (n == bp_n) backpressure(out_n);
      b = 0;
      while (exp_q.size() != 0 && b < 200) begin
        tick();
        b++;
      end
      if (exp_q.size() != 0) chk("tmo_sm", 0, 1);
    end
    b = 0;
    while (done_n == d0 && b < 200) begin
      tick();
      b++;
    end
    chk("done_cyc", done_cyc,
        len == 0 ? st_cyc + 12 : acc_cyc + 1);
    repeat (3) tick();
    chk("done_once", done_n, d0 + 1);
    chk("idle_end", ap_idle, 1);
    chk("tlast_err", tlast_err, bad_last);
    chk("q_empty", exp_q.size(), 0);
  endtask

  initial begin
    int d0, b;
    for (int i = 0; i < 16; i++) begin
      data_mem[i] = 32'hDEAD_0000 + i;
      tap_mem[i]  = '0;
    end
    #1;
    chk("rst_outs", any_out, 0);
    chk("rst_idle", ap_idle, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // impulse response
    for (int i = 0; i < NTAP; i++) tap_mem[i] = i + 1;
    for (int i = 0; i < 64; i++) xs[i] = (i == 0);
    run(12, -1, 0, 0);

    // single-sample cycle timing
    xs[0] = 7;
    en_n = 0;
    vld_first = -1;
    run(1, -1, 0, 0);
    chk("t2_clr", clr_cyc, hs_cyc);
    chk("t2_en_first", en_first, hs_cyc + 2);
    chk("t2_en_last", en_last, hs_cyc + 12);
    chk("t2_en_n", en_n, 11);
    chk("t2_valid", vld_first, hs_cyc + 13);

    // backpressure on the second result
    for (int i = 0; i < NTAP; i++)
      tap_mem[i] = $urandom_range(1, 9);
    for (int i = 0; i < 64; i++)
      xs[i] = $urandom_range(1, 200);
    run(4, 1, 0, 0);

    // circular wrap, ramp through unit taps
    for (int i = 0; i < NTAP; i++) tap_mem[i] = 1;
    for (int i = 0; i < 64; i++) xs[i] = i + 1;
    run(30, -1, 0, 0);

    // zero-length run, then a run with ap_start while busy
    strm_n = 0;
    run(0, -1, 0, 0);
    chk("t5_no_stream", strm_n, 0);
    run(3, -1, 0, 1);

    // wrong tlast marking sets the sticky flag
    run(2, -1, 1, 0);

    // reset in the middle of the tap walk
    for (int i = 0; i < NTAP; i++) tap_mem[i] = i + 1;
    for (int i = 0; i < 64; i++) xs[i] = (i == 0);
    d0 = done_n;
    start(12);
    ss_tvalid = 1'b1;
    ss_tdata  = 1;
    ss_tlast  = 1'b0;
    b = 0;
    @(negedge clk);
    while (!(tap_EN && tap_A == 12'd20) && b < 200) begin
      ss_tvalid = ss_tready ? 1'b1 : 1'b0;
      @(negedge clk);
      b++;
    end
    if (b >= 200) chk("tmo_k5", 0, 1);
    ss_tvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", any_out, 0);
    chk("rst_mid_idle", ap_idle, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_no_done", done_n, d0);
    run(12, -1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
